led_mode_ctrl: RTL and testbench

Control block that sequences the shift/flash LED datapath. It synchronises and debounces the four push-buttons and turns them into one-cycle events. A small state machine holds the display mode and the one-hot RGB colour. A programmable tick generator paces the datapath, with its rate selected from the switches.

---
 rtl/led_ctrl_pkg.sv | 12 +
 rtl/btn_debounce.sv | 33 +++
 rtl/led_mode_ctrl.sv | 72 +++++++
 tb/tb_led_mode_ctrl.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/led_ctrl_pkg.sv
// led_ctrl_pkg: shared state encoding, colour/mode constants and tick-limit helper
package led_ctrl_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, RUN_SR = 2'd1, RUN_FLASH = 2'd2} state_t;
  localparam logic [2:0] COLOR_RED   = 3'b001;
  localparam logic [2:0] COLOR_GREEN = 3'b010;
  localparam logic [2:0] COLOR_BLUE  = 3'b100;
  localparam logic MODE_SR    = 1'b0;
  localparam logic MODE_FLASH = 1'b1;
  function automatic logic [31:0] tick_limit(input int sel, input int nb_count);
    return (32'd1 << (nb_count - 4 + sel)) - 32'd1;
  endfunction
endpackage

// File: rtl/btn_debounce.sv
// btn_debounce: 2-FF synchroniser, stable-count debouncer and registered rising-edge pulse
module btn_debounce #(
  parameter int DEB_CYCLES = 1000
) (
  input  logic clock,
  input  logic ck_rst,
  input  logic btn,
  output logic rise
);
  localparam int CW = $clog2(DEB_CYCLES);
  logic sync1, sync2, level, level_d;
  logic [CW-1:0] cnt;
  always_ff @(posedge clock or negedge ck_rst) begin
    if (!ck_rst) begin
      sync1   <= 1'b0;
      sync2   <= 1'b0;
      level   <= 1'b0;
      level_d <= 1'b0;
      rise    <= 1'b0;
      cnt     <= '0;
    end else begin
      sync1   <= btn;
      sync2   <= sync1;
      level_d <= level;
      rise    <= level & ~level_d;
      if (sync2 == level) cnt <= '0;
      else if (cnt == CW'(DEB_CYCLES - 1)) begin
        level <= sync2;
        cnt   <= '0;
      end else cnt <= cnt + 1'b1;
    end
  end
endmodule

// File: rtl/led_mode_ctrl.sv
// led_mode_ctrl: button events, mode/colour FSM and programmable tick generator
module led_mode_ctrl
  import led_ctrl_pkg::*;
#(
  parameter int NB_BTN     = 4,
  parameter int NB_SW      = 4,
  parameter int NB_SEL     = 2,
  parameter int NB_COUNT   = 14,
  parameter int DEB_CYCLES = 1000
) (
  input  logic              clock,
  input  logic              ck_rst,
  input  logic [NB_SW-1:0]  i_sw,
  input  logic [NB_BTN-1:0] i_btn,
  output logic              o_enable,
  output logic              o_mode,
  output logic [2:0]        o_color,
  output logic              o_tick,
  output logic [NB_BTN-1:0] o_btn_event
);
  state_t state, state_d;
  logic mode_d, tick_d, run;
  logic [2:0] color_d;
  logic [NB_COUNT-1:0] cnt, cnt_d;
  logic [31:0] limit;
  logic unused_sw;
  assign unused_sw = ^i_sw[NB_SW-1:NB_SEL+1];
  for (genvar i = 0; i < NB_BTN; i++) begin : g_btn
    btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb (
      .clock(clock),
      .ck_rst(ck_rst),
      .btn(i_btn[i]),
      .rise(o_btn_event[i])
    );
  end
  always_ff @(posedge clock or negedge ck_rst) begin
    if (!ck_rst) begin
      state    <= IDLE;
      o_enable <= 1'b0;
      o_mode   <= MODE_SR;
      o_color  <= COLOR_RED;
      o_tick   <= 1'b0;
      cnt      <= '0;
    end else begin
      state    <= state_d;
      o_enable <= i_sw[0];
      o_mode   <= mode_d;
      o_color  <= color_d;
      o_tick   <= tick_d;
      cnt      <= cnt_d;
    end
  end
  always_comb begin
    state_d = !o_enable ? IDLE
            : state == IDLE ? (o_mode ? RUN_FLASH : RUN_SR)
            : o_btn_event[0] ? (state == RUN_SR ? RUN_FLASH : RUN_SR)
            : state;
  end
  // a shrinking limit is caught by >= on the next cycle instead of wrapping the counter
  always_comb begin
    run     = state != IDLE;
    limit   = tick_limit(int'(i_sw[NB_SEL:1]), NB_COUNT);
    mode_d  = (run && o_btn_event[0]) ? ~o_mode : o_mode;
    color_d = !run ? o_color
            : o_btn_event[1] ? COLOR_RED
            : o_btn_event[2] ? COLOR_GREEN
            : o_btn_event[3] ? COLOR_BLUE
            : o_color;
    tick_d  = run && (32'(cnt) >= limit);
    cnt_d   = (!run || tick_d) ? '0 : cnt + 1'b1;
  end
endmodule

// File: tb/tb_led_mode_ctrl.sv
// tb_led_mode_ctrl: directed scenarios plus randomized stimulus against a behavioural model
module tb_led_mode_ctrl;
  localparam int DEB = 4;
  logic clock = 1'b0, ck_rst = 1'b0;
  logic [3:0] i_sw = '0, i_btn = '0;
  logic o_enable, o_mode, o_tick;
  logic [2:0] o_color;
  logic [3:0] o_btn_event;
  int tests = 0, fails = 0, cyc = 0;
  int ev_cnt[4], ev_at[4], hold_left[4];
  int mode_at = 0, color_at = 0, tick_cnt = 0, tick_at = 0;
  int t0, t1, k, ev0, ca;
  logic last_mode = 1'b0;
  logic [2:0] last_color = 3'b001;
  bit chk_on = 0;

  led_mode_ctrl #(.NB_BTN(4), .NB_SW(4), .NB_SEL(2), .NB_COUNT(14), .DEB_CYCLES(DEB)) dut (
    .clock(clock), .ck_rst(ck_rst), .i_sw(i_sw), .i_btn(i_btn),
    .o_enable(o_enable), .o_mode(o_mode), .o_color(o_color),
    .o_tick(o_tick), .o_btn_event(o_btn_event)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  // model state: raw history, accepted levels, stable-run lengths, outputs
  typedef struct packed {
    logic [3:0] h1, h2, acc, accp, ev;
    logic [3:0][7:0] run;
    logic en, running, mode, tick;
    logic [2:0] color;
    logic [15:0] cnt;
  } model_t;
  model_t m;

  function automatic model_t model_reset();
    model_t r = '0;
    r.color = 3'b001;
    return r;
  endfunction

  function automatic model_t model_next(model_t c, logic [3:0] btn, logic [3:0] sw);
    model_t n = c;
    int lim;
    for (int i = 0; i < 4; i++) begin
      logic s;
      s = c.h2[i];
      n.h2[i] = c.h1[i];
      n.h1[i] = btn[i];
      n.ev[i] = c.acc[i] & ~c.accp[i];
      n.accp[i] = c.acc[i];
      if (s != c.acc[i]) begin
        n.run[i] = c.run[i] + 8'd1;
        if (n.run[i] == 8'(DEB)) begin
          n.acc[i] = s;
          n.run[i] = '0;
        end
      end else n.run[i] = '0;
    end
    n.en = sw[0];
    n.running = c.en;
    if (c.running && c.ev[0]) n.mode = ~c.mode;
    if (c.running) n.color = c.ev[1] ? 3'b001 : c.ev[2] ? 3'b010 : c.ev[3] ? 3'b100 : c.color;
    lim = (1 << (10 + int'(sw[2:1]))) - 1;
    if (!c.running) begin
      n.cnt = '0;
      n.tick = 1'b0;
    end else if (int'(c.cnt) >= lim) begin
      n.cnt = '0;
      n.tick = 1'b1;
    end else begin
      n.cnt = c.cnt + 16'd1;
      n.tick = 1'b0;
    end
    return n;
  endfunction

  initial m = model_reset();
  always @(posedge clock or negedge ck_rst)
    if (!ck_rst) m <= model_reset();
    else m <= model_next(m, i_btn, i_sw);

  always @(negedge clock) if (chk_on) begin
    tests++;
    if ({o_enable, o_mode, o_color, o_tick, o_btn_event} !== {m.en, m.mode, m.color, m.tick, m.ev}) begin
      fails++;
      $display("FAIL model_cmp cyc=%0d: dut en=%b mode=%b color=%b tick=%b ev=%b, expected en=%b mode=%b color=%b tick=%b ev=%b",
               cyc, o_enable, o_mode, o_color, o_tick, o_btn_event, m.en, m.mode, m.color, m.tick, m.ev);
    end
  end

  always @(negedge clock) if (chk_on) begin
    for (int i = 0; i < 4; i++) if (o_btn_event[i]) begin
      ev_cnt[i]++;
      ev_at[i] = cyc;
    end
    if (o_mode !== last_mode) begin
      mode_at = cyc;
      last_mode = o_mode;
    end
    if (o_color !== last_color) begin
      color_at = cyc;
      last_color = o_color;
    end
    if (o_tick) begin
      tick_cnt++;
      tick_at = cyc;
    end
  end

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(negedge clock);
    #1;
  endtask

  task automatic press(input logic [3:0] b, input int hold, input int after);
    i_btn = b;
    repeat (hold) step();
    i_btn = '0;
    repeat (after) step();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    repeat (3) step();
    ck_rst = 1'b1;
    chk_on = 1;
    check("rst_color", int'(o_color), 1);
    check("rst_mode", int'(o_mode), 0);
    check("rst_enable", int'(o_enable), 0);
    check("rst_tick", int'(o_tick), 0);
    check("rst_event", int'(o_btn_event), 0);
    repeat (500) step();
    check("idle_no_tick", tick_cnt, 0);

    // enable register, then state entry, then limit+1 = 1024 cycles
    i_sw = 4'b0001;
    t0 = cyc;
    k = tick_cnt;
    for (int n = 0; n < 3000 && tick_cnt == k; n++) step();
    check("first_tick", tick_at - t0, 1026);
    t1 = tick_at;
    for (int n = 0; n < 3000 && tick_cnt == k + 1; n++) step();
    check("tick_period", tick_at - t1, 1024);

    t0 = cyc;
    ev0 = ev_cnt[0];
    press(4'b0001, 20, 20);
    check("btn0_event_lat", ev_at[0] - t0, DEB + 3);
    check("btn0_event_cnt", ev_cnt[0] - ev0, 1);
    check("btn0_mode", int'(o_mode), 1);
    check("mode_after_event", mode_at - ev_at[0], 1);
    ev0 = ev_cnt[0];
    press(4'b0001, 3, 20);
    check("glitch_no_event", ev_cnt[0] - ev0, 0);
    check("glitch_mode", int'(o_mode), 1);

    ca = color_at;
    press(4'b0010, 20, 10);
    check("red_same", int'(o_color), 1);
    check("red_same_nochange", color_at, ca);
    press(4'b0100, 20, 10);
    check("green", int'(o_color), 2);
    press(4'b1000, 20, 10);
    check("blue", int'(o_color), 4);
    check("color_after_event", color_at - ev_at[3], 1);
    i_sw = 4'b0000;
    repeat (3) step();
    ev0 = ev_cnt[1];
    press(4'b0010, 20, 10);
    check("idle_event_seen", ev_cnt[1] - ev0, 1);
    check("idle_color_held", int'(o_color), 4);
    check("idle_mode_held", int'(o_mode), 1);

    i_sw = 4'b0001;
    repeat (3) step();
    press(4'b1010, 20, 10);
    check("red_over_blue", int'(o_color), 1);
    press(4'b0101, 20, 10);
    check("combo_mode", int'(o_mode), 0);
    check("combo_color", int'(o_color), 2);
    check("combo_same_cycle", mode_at, color_at);

    i_sw = 4'b0000;
    repeat (3) step();
    i_sw = 4'b0111;
    t0 = cyc;
    k = tick_cnt;
    repeat (5002) step();
    check("sel3_no_tick", tick_cnt - k, 0);
    i_sw = 4'b0001;
    t1 = cyc;
    step();
    check("shrink_tick", int'(o_tick), 1);
    repeat (1023) step();
    check("restart_no_tick", int'(o_tick), 0);
    step();
    check("restart_tick", int'(o_tick), 1);
    repeat (300) step();
    i_btn = 4'b0100;
    @(posedge clock);
    #2;
    ck_rst = 1'b0;
    #1;
    check("async_enable", int'(o_enable), 0);
    check("async_mode", int'(o_mode), 0);
    check("async_color", int'(o_color), 1);
    check("async_tick", int'(o_tick), 0);
    check("async_event", int'(o_btn_event), 0);
    i_btn = '0;
    repeat (2) step();
    ck_rst = 1'b1;

    i_sw = 4'b0001;
    for (int n = 0; n < 6000; n++) begin
      for (int b = 0; b < 4; b++) begin
        if (hold_left[b] == 0) begin
          i_btn[b] = 1'($urandom_range(0, 1));
          hold_left[b] = $urandom_range(1, 10);
        end
        hold_left[b]--;
      end
      if ($urandom_range(0, 299) == 0) i_sw[0] = ~i_sw[0];
      if ($urandom_range(0, 199) == 0) i_sw[2:1] = 2'($urandom_range(0, 3));
      i_sw[3] = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 1999) == 0) begin
        ck_rst = 1'b0;
        step();
        ck_rst = 1'b1;
      end
      step();
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
